el2_btb_wr_sched: RTL and testbench
===================================

Name: el2_btb_wr_sched

Overview:
- Owns the single write port of the branch target buffer (BTB) arrays.
- Sequences a full-array invalidate walk after reset and on flush requests.
- Outside a walk, arbitrates between mispredict/training updates from EXU and ECC-error single-entry invalidates from the IFU.
- Sits between the predictor update logic, which supplies already-hashed indices and tags, and the BTB tag/data/valid flops.

Parameters:
- IDX_W, 8, BTB index width; array has 2**IDX_W sets.
- TAG_W, 5, folded BTB tag width.
- DATA_W, 32, payload width (target[31:1], prediction hint bits).
- NWAY, 2, BTB associativity.
- INVQ_DEPTH, 2, invalidate queue depth (power of 2, >=2).

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset; asynchronous, active-low
- flush_req  in  1  start (or restart) full-array invalidate walk
- upd_valid  in  1  EXU update request; never back-pressured
- upd_index  in  IDX_W  hashed set index
- upd_tag  in  TAG_W  hashed tag
- upd_way  in  NWAY  one-hot target way
- upd_data  in  DATA_W  entry payload
- inv_valid  in  1  single-entry invalidate request
- inv_index  in  IDX_W  set to invalidate
- inv_way  in  NWAY  one-hot way(s) to invalidate
- inv_ready  out  1  invalidate accepted when inv_valid & inv_ready
- btb_wr_en  out  NWAY  per-way write enable
- btb_wr_index  out  IDX_W  write set
- btb_wr_tag  out  TAG_W  write tag
- btb_wr_data  out  DATA_W  write payload
- btb_wr_vld  out  1  valid bit written (1 = update, 0 = invalidate)
- walk_busy  out  1  invalidate walk in progress
- walk_done  out  1  one-cycle pulse at walk completion
- upd_drop_cnt  out  8  saturating count of updates dropped during walks

Behaviour:
- Reset (rst_l low, asynchronous):
  - state=WALK, walk counter=0, queue empty.
  - All btb_wr_* outputs 0; walk_done=0; upd_drop_cnt=0.
  - walk_busy=1, inv_ready=0.
- States: WALK, RUN.
- WALK:
  - Each cycle, register a write to set = counter: btb_wr_en=all ones, btb_wr_vld=0, tag/data=0. Then counter+1.
  - When the write to set 2**IDX_W-1 issues, the next state is RUN and walk_done pulses in that same first RUN cycle.
  - Walk length is exactly 2**IDX_W cycles after reset deassertion.
- flush_req:
  - In RUN: next state WALK, counter=0, invalidate queue emptied (pending entries discarded; the walk supersedes them).
  - In WALK: counter restarts at 0; no walk_done for the aborted walk.
  - Simultaneous with upd_valid or inv_valid: the flush wins; the request is dropped (upd counts as a drop; inv is not accepted because inv_ready=0 the next cycle, and the same-cycle acceptance is discarded by the queue clear).
- RUN arbitration (one write per cycle, registered, latency 1):
  - Priority: upd_valid > invalidate-queue head.
  - upd_valid produces btb_wr_en=upd_way, btb_wr_vld=1, tag/data/index from upd_* on the next cycle.
  - Queue head produces btb_wr_en=inv_way, btb_wr_vld=0, tag/data=0, and is popped.
  - No request: btb_wr_en=0; other write outputs hold their last value.
- Invalidate queue:
  - FIFO of INVQ_DEPTH {index, way}; inv_ready = RUN & !full.
  - A push is allowed at full in the same cycle as a pop? No: inv_ready reflects registered fullness only.
  - An inv pushed into an empty queue with no upd pending writes on the cycle after the push (total latency 2).
  - Pointers wrap modulo INVQ_DEPTH.
- Updates during WALK: discarded; upd_drop_cnt increments, saturating at 255; cleared only by reset.
- Same set/way targeted by upd and a queued inv: both writes issue in arbitration order (update first, invalidate later). The final state is invalid; this is intended for error containment.
- An upd_way or inv_way of zero is legal and produces no write enable, but still consumes the arbitration slot.

Decomposition:
- Shared package el2_btb_pkg:
  - btb_wr_t struct {en, index, tag, data, vld}
  - inv_req_t struct {index, way}
  - walk state enum {WALK, RUN}
- One sub-module: el2_btb_invq, a parameterised FIFO with registered full/empty and a synchronous clear input.

Test Plan:
- Reset release, IDX_W=8 -> 256 consecutive writes, index 0..255, btb_wr_en=2'b11, btb_wr_vld=0; walk_done pulses in cycle 257; walk_busy falls with it.
- RUN, upd_valid with index=0x3A, way=2'b10, data=0x8000_1234 -> next cycle btb_wr_en=2'b10, btb_wr_index=0x3A, btb_wr_vld=1, data matches.
- Three back-to-back invs with upd_valid held high -> inv_ready drops after 2 accepts; once upd releases, the 2 invalidates drain in order, one per cycle.
- flush_req at walk counter=100 -> next write index=0; total 256 further cycles; exactly one walk_done.
- 300 upd_valid cycles during walks -> upd_drop_cnt saturates at 255.
- rst_l asserted mid-RUN with queue holding 2 entries -> outputs immediately 0, queue empty, walk restarts at index 0 after release.

Source files
------------

// File: rtl/el2_btb_pkg.sv
// el2_btb_pkg: shared types for the BTB write scheduler and its invalidate queue.
package el2_btb_pkg;
  localparam int BTB_IDX_W  = 8;
  localparam int BTB_TAG_W  = 5;
  localparam int BTB_DATA_W = 32;
  localparam int BTB_NWAY   = 2;
  typedef struct packed {
    logic [BTB_NWAY-1:0]   en;
    logic [BTB_IDX_W-1:0]  index;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_DATA_W-1:0] data;
    logic                  vld;
  } btb_wr_t;
  typedef struct packed {
    logic [BTB_IDX_W-1:0] index;
    logic [BTB_NWAY-1:0]  way;
  } inv_req_t;
  typedef enum logic {WALK = 1'b0, RUN = 1'b1} walk_state_e;
endpackage

// File: rtl/el2_btb_invq.sv
// el2_btb_invq: small FIFO with registered full/empty and a synchronous clear.
module el2_btb_invq #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] n, n_nxt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign n_nxt   = n + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout    = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l || clr) begin
      wp    <= '0;
      rp    <= '0;
      n     <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      n     <= n_nxt;
      full  <= n_nxt == (AW+1)'(DEPTH);
      empty <= n_nxt == '0;
    end
  end
endmodule

// File: rtl/el2_btb_wr_sched.sv
// el2_btb_wr_sched: owns the BTB write port; runs invalidate walks and
// arbitrates EXU updates against queued single-entry invalidates.
module el2_btb_wr_sched
  import el2_btb_pkg::*;
#(
  parameter int IDX_W      = BTB_IDX_W,
  parameter int TAG_W      = BTB_TAG_W,
  parameter int DATA_W     = BTB_DATA_W,
  parameter int NWAY       = BTB_NWAY,
  parameter int INVQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              flush_req,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic [NWAY-1:0]   upd_way,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              inv_valid,
  input  logic [IDX_W-1:0]  inv_index,
  input  logic [NWAY-1:0]   inv_way,
  output logic              inv_ready,
  output logic [NWAY-1:0]   btb_wr_en,
  output logic [IDX_W-1:0]  btb_wr_index,
  output logic [TAG_W-1:0]  btb_wr_tag,
  output logic [DATA_W-1:0] btb_wr_data,
  output logic              btb_wr_vld,
  output logic              walk_busy,
  output logic              walk_done,
  output logic [7:0]        upd_drop_cnt
);
  walk_state_e state;
  logic [IDX_W-1:0] cnt;
  btb_wr_t wr;
  inv_req_t head;
  logic [IDX_W+NWAY-1:0] head_bits;
  logic full, empty, push, pop;
  assign walk_busy    = state == WALK;
  assign inv_ready    = state == RUN && !full;
  assign push         = inv_valid && inv_ready;
  assign pop          = state == RUN && !flush_req && !upd_valid && !empty;
  assign head         = inv_req_t'(head_bits);
  assign btb_wr_en    = wr.en;
  assign btb_wr_index = wr.index;
  assign btb_wr_tag   = wr.tag;
  assign btb_wr_data  = wr.data;
  assign btb_wr_vld   = wr.vld;
  // A flush clears the queue so stale invalidates never outlive the walk that covers them.
  el2_btb_invq #(.W(IDX_W+NWAY), .DEPTH(INVQ_DEPTH)) u_invq (
    .clk   (clk),
    .rst_l (rst_l),
    .clr   (flush_req),
    .push  (push),
    .din   ({inv_index, inv_way}),
    .pop   (pop),
    .dout  (head_bits),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= WALK;
      cnt          <= '0;
      wr           <= '0;
      walk_done    <= 1'b0;
      upd_drop_cnt <= '0;
    end else begin
      walk_done <= 1'b0;
      if (upd_valid && (state == WALK || flush_req) && upd_drop_cnt != 8'hff)
        upd_drop_cnt <= upd_drop_cnt + 8'd1;
      if (flush_req) begin
        state  <= WALK;
        cnt    <= '0;
        wr.en  <= '0;
      end else if (state == WALK) begin
        wr  <= '{en: '1, index: cnt, tag: '0, data: '0, vld: 1'b0};
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state     <= RUN;
          walk_done <= 1'b1;
        end
      end else if (upd_valid) begin
        wr <= '{en: upd_way, index: upd_index, tag: upd_tag, data: upd_data, vld: 1'b1};
      end else if (!empty) begin
        wr <= '{en: head.way, index: head.index, tag: '0, data: '0, vld: 1'b0};
      end else begin
        wr.en <= '0;
      end
    end
  end
endmodule

// File: tb/tb_el2_btb_wr_sched.sv
// tb_el2_btb_wr_sched: directed self-checking bench for the BTB write scheduler.
module tb_el2_btb_wr_sched;
  logic clk, rst_l, flush_req, upd_valid, inv_valid, inv_ready;
  logic [7:0] upd_index, inv_index, btb_wr_index, upd_drop_cnt;
  logic [4:0] upd_tag, btb_wr_tag;
  logic [1:0] upd_way, inv_way, btb_wr_en;
  logic [31:0] upd_data, btb_wr_data;
  logic btb_wr_vld, walk_busy, walk_done;
  int n_chk = 0, n_fail = 0, n_done = 0, bad = 0;

  el2_btb_wr_sched dut (
    .clk(clk), .rst_l(rst_l), .flush_req(flush_req),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_tag(upd_tag),
    .upd_way(upd_way), .upd_data(upd_data),
    .inv_valid(inv_valid), .inv_index(inv_index), .inv_way(inv_way),
    .inv_ready(inv_ready), .btb_wr_en(btb_wr_en), .btb_wr_index(btb_wr_index),
    .btb_wr_tag(btb_wr_tag), .btb_wr_data(btb_wr_data), .btb_wr_vld(btb_wr_vld),
    .walk_busy(walk_busy), .walk_done(walk_done), .upd_drop_cnt(upd_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [7:0] idx, input logic [1:0] way, input logic [31:0] d);
    upd_valid = v; upd_index = idx; upd_way = way; upd_data = d; upd_tag = idx[4:0];
  endtask

  task automatic inv(input logic v, input logic [7:0] idx, input logic [1:0] way);
    inv_valid = v; inv_index = idx; inv_way = way;
  endtask

  // Runs a full walk from index 0, counting index/enable errors and walk_done pulses.
  task automatic full_walk();
    bad = 0; n_done = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (btb_wr_en !== 2'b11 || btb_wr_index !== 8'(i) || btb_wr_vld !== 1'b0) bad++;
      if (walk_done) n_done++;
      if (i < 255 && !walk_busy) bad++;
    end
    chk("walk_writes_bad", 64'(bad), 0);
    chk("walk_done_count", 64'(n_done), 1);
    chk("walk_done_last", 64'(walk_done), 1);
    chk("walk_busy_end", 64'(walk_busy), 0);
  endtask

  initial begin
    rst_l = 1'b0; flush_req = 1'b0;
    upd(0, 0, 0, 0); inv(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(btb_wr_en), 0);
    chk("rst_wr_index", 64'(btb_wr_index), 0);
    chk("rst_wr_vld", 64'(btb_wr_vld), 0);
    chk("rst_walk_busy", 64'(walk_busy), 1);
    chk("rst_inv_ready", 64'(inv_ready), 0);
    chk("rst_walk_done", 64'(walk_done), 0);
    chk("rst_drop", 64'(upd_drop_cnt), 0);
    rst_l = 1'b1;
    full_walk();
    tick();
    chk("post_walk_done", 64'(walk_done), 0);
    chk("post_walk_en", 64'(btb_wr_en), 0);
    chk("post_walk_ready", 64'(inv_ready), 1);

    upd(1, 8'h3A, 2'b10, 32'h8000_1234);
    tick();
    upd(0, 0, 0, 0);
    chk("upd_en", 64'(btb_wr_en), 2'b10);
    chk("upd_index", 64'(btb_wr_index), 8'h3A);
    chk("upd_tag", 64'(btb_wr_tag), 5'h1A);
    chk("upd_data", 64'(btb_wr_data), 32'h8000_1234);
    chk("upd_vld", 64'(btb_wr_vld), 1);
    tick();
    chk("idle_en", 64'(btb_wr_en), 0);
    chk("idle_hold_index", 64'(btb_wr_index), 8'h3A);
    chk("idle_hold_data", 64'(btb_wr_data), 32'h8000_1234);

    upd(1, 8'h11, 2'b01, 32'h0000_0042);
    inv(1, 8'h20, 2'b01);
    chk("q_ready0", 64'(inv_ready), 1);
    tick();
    chk("q_upd_first", 64'(btb_wr_index), 8'h11);
    chk("q_ready1", 64'(inv_ready), 1);
    inv(1, 8'h21, 2'b10);
    tick();
    chk("q_ready_full", 64'(inv_ready), 0);
    inv(1, 8'h22, 2'b11);
    tick();
    chk("q_ready_still_full", 64'(inv_ready), 0);
    chk("q_upd_en", 64'(btb_wr_en), 2'b01);
    upd(0, 0, 0, 0); inv(0, 0, 0);
    tick();
    chk("q_drain0_index", 64'(btb_wr_index), 8'h20);
    chk("q_drain0_en", 64'(btb_wr_en), 2'b01);
    chk("q_drain0_vld", 64'(btb_wr_vld), 0);
    chk("q_drain0_data", 64'(btb_wr_data), 0);
    chk("q_ready_after_pop", 64'(inv_ready), 1);
    tick();
    chk("q_drain1_index", 64'(btb_wr_index), 8'h21);
    chk("q_drain1_en", 64'(btb_wr_en), 2'b10);
    tick();
    chk("q_third_dropped", 64'(btb_wr_en), 0);

    inv(1, 8'h40, 2'b10);
    tick();
    inv(0, 0, 0);
    chk("lat2_not_yet", 64'(btb_wr_en), 0);
    tick();
    chk("lat2_en", 64'(btb_wr_en), 2'b10);
    chk("lat2_index", 64'(btb_wr_index), 8'h40);

    inv(1, 8'h50, 2'b01);
    tick();
    inv(0, 0, 0);
    upd(1, 8'h60, 2'b00, 32'h1);
    tick();
    upd(0, 0, 0, 0);
    chk("zero_way_en", 64'(btb_wr_en), 0);
    chk("zero_way_index", 64'(btb_wr_index), 8'h60);
    chk("zero_way_vld", 64'(btb_wr_vld), 1);
    tick();
    chk("after_zero_inv_index", 64'(btb_wr_index), 8'h50);
    chk("after_zero_inv_en", 64'(btb_wr_en), 2'b01);

    inv(1, 8'h70, 2'b11);
    tick();
    flush_req = 1'b1;
    upd(1, 8'h71, 2'b01, 32'h5);
    inv(1, 8'h72, 2'b01);
    tick();
    flush_req = 1'b0; upd(0, 0, 0, 0); inv(0, 0, 0);
    chk("flush_en", 64'(btb_wr_en), 0);
    chk("flush_busy", 64'(walk_busy), 1);
    chk("flush_ready", 64'(inv_ready), 0);
    chk("flush_drop", 64'(upd_drop_cnt), 1);
    repeat (100) tick();
    chk("walk_at_99", 64'(btb_wr_index), 8'd99);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("reflush_en", 64'(btb_wr_en), 0);
    full_walk();
    tick();
    chk("flushed_q_empty", 64'(btb_wr_en), 0);

    flush_req = 1'b1;
    upd(1, 8'h01, 2'b01, 32'h9);
    tick();
    flush_req = 1'b0;
    repeat (250) tick();
    chk("drop_252", 64'(upd_drop_cnt), 252);
    repeat (5) tick();
    chk("drop_sat", 64'(upd_drop_cnt), 255);
    chk("drop_still_walk", 64'(walk_busy), 1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (45) tick();
    chk("drop_sat_hold", 64'(upd_drop_cnt), 255);
    upd(0, 0, 0, 0);
    n_done = 0;
    for (int i = 0; i < 211; i++) begin
      tick();
      if (walk_done) n_done++;
    end
    chk("walk_end_after_restart", 64'(n_done), 1);
    chk("run_after_restart", 64'(walk_busy), 0);

    upd(1, 8'h90, 2'b10, 32'hABCD);
    inv(1, 8'h80, 2'b01);
    tick();
    inv(1, 8'h81, 2'b10);
    tick();
    inv(0, 0, 0);
    chk("pre_rst_full", 64'(inv_ready), 0);
    chk("pre_rst_en", 64'(btb_wr_en), 2'b10);
    #1;
    rst_l = 1'b0;
    #1;
    chk("arst_en", 64'(btb_wr_en), 0);
    chk("arst_index", 64'(btb_wr_index), 0);
    chk("arst_data", 64'(btb_wr_data), 0);
    chk("arst_busy", 64'(walk_busy), 1);
    chk("arst_drop", 64'(upd_drop_cnt), 0);
    upd(0, 0, 0, 0);
    rst_l = 1'b1;
    full_walk();
    tick();
    chk("arst_q_empty", 64'(btb_wr_en), 0);
    chk("arst_ready", 64'(inv_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
